imem_arbiter: RTL and testbench

IMEM_ARBITER -- requirements
Module: imem_arbiter

---
 rtl/imem_arbiter.sv | 171 +++++++++++++++++
 tb/tb_imem_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : imem_arbiter                                                 |
// | Description : Single-port instruction memory arbiter between core fetch    |
// |               and a loader/debug port; fixed read latency of one cycle.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module imem_arbiter #(
  parameter int DEPTH    = 1024,
  parameter int MAX_WAIT = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  // fetch port
  input  logic                     f_req,
  input  logic [31:0]              f_addr,
  output logic                     f_gnt,
  output logic                     f_rvalid,
  output logic [31:0]              f_rdata,
  output logic                     f_err,
  // loader / debug port
  input  logic                     l_req,
  input  logic                     l_we,
  input  logic                     l_lock,
  input  logic [31:0]              l_addr,
  input  logic [31:0]              l_wdata,
  output logic                     l_gnt,
  output logic                     l_rvalid,
  output logic [31:0]              l_rdata,
  output logic                     l_err,
  // single-port memory
  output logic                     m_en,
  output logic                     m_we,
  output logic [$clog2(DEPTH)-1:0] m_addr,
  output logic [31:0]              m_wdata,
  input  logic [31:0]              m_rdata
);

  localparam int              c_AW       = $clog2(DEPTH);
  localparam int              c_WW       = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [c_WW-1:0] c_WAIT_MAX = c_WW'(MAX_WAIT);
  localparam logic [31:0]     c_DEPTH    = 32'(DEPTH);

  typedef enum logic [0:0] {
    ST_NORMAL = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [c_WW-1:0] wait_q, wait_d;

  // Pending response: captured in the grant cycle, presented the next cycle.
  logic rsp_vld_q, rsp_vld_d;
  logic rsp_ldr_q, rsp_ldr_d;
  logic rsp_err_q, rsp_err_d;
  logic rsp_rd_q,  rsp_rd_d;

  logic        w_f_bad;
  logic        w_l_bad;
  logic        w_gnt_any;
  logic        w_sel_bad;
  logic        w_rsp_live;
  logic [31:0] w_rsp_data;

  // Misaligned or beyond the end of memory: granted but never reaches the array.
  assign w_f_bad = (f_addr[1:0] != 2'b00) || ({2'b00, f_addr[31:2]} >= c_DEPTH);
  assign w_l_bad = (l_addr[1:0] != 2'b00) || ({2'b00, l_addr[31:2]} >= c_DEPTH);

  // --------------------------------------------------------------------------
  // Arbitration and lock FSM
  // --------------------------------------------------------------------------
  always_comb begin
    f_gnt   = 1'b0;
    l_gnt   = 1'b0;
    state_d = state_q;
    wait_d  = '0;
    if (!reset) begin
      case (state_q)
        ST_NORMAL: begin
          if (l_req && (!f_req || (wait_q == c_WAIT_MAX))) begin
            l_gnt = 1'b1;
          end else begin
            f_gnt = f_req;
          end
          if (l_req && !l_gnt) begin
            wait_d = (wait_q == c_WAIT_MAX) ? wait_q : wait_q + 1'b1;
          end
        end
        ST_LOCKED: begin
          l_gnt = l_req;
        end
        default: begin
          state_d = ST_NORMAL;
        end
      endcase
      if (l_gnt) begin
        state_d = l_lock ? ST_LOCKED : ST_NORMAL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_NORMAL;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // --------------------------------------------------------------------------
  // Memory request mux
  // --------------------------------------------------------------------------
  assign w_gnt_any = f_gnt | l_gnt;
  assign w_sel_bad = l_gnt ? w_l_bad : w_f_bad;

  always_comb begin
    m_en    = w_gnt_any & ~w_sel_bad;
    m_we    = m_en & l_gnt & l_we;
    m_addr  = '0;
    m_wdata = '0;
    if (m_en) begin
      m_addr  = l_gnt ? l_addr[c_AW+1:2] : f_addr[c_AW+1:2];
      m_wdata = l_wdata;
    end
  end

  // --------------------------------------------------------------------------
  // Response path
  // --------------------------------------------------------------------------
  always_comb begin
    rsp_vld_d = w_gnt_any;
    rsp_ldr_d = l_gnt;
    rsp_err_d = w_gnt_any & w_sel_bad;
    rsp_rd_d  = ~(l_gnt & l_we);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_vld_q <= 1'b0;
      rsp_ldr_q <= 1'b0;
      rsp_err_q <= 1'b0;
      rsp_rd_q  <= 1'b0;
    end else begin
      rsp_vld_q <= rsp_vld_d;
      rsp_ldr_q <= rsp_ldr_d;
      rsp_err_q <= rsp_err_d;
      rsp_rd_q  <= rsp_rd_d;
    end
  end

  // A response still in flight when reset rises is suppressed in that same cycle.
  assign w_rsp_live = rsp_vld_q & ~reset;
  assign w_rsp_data = (rsp_rd_q & ~rsp_err_q) ? m_rdata : 32'h0;

  always_comb begin
    f_rvalid = w_rsp_live & ~rsp_ldr_q;
    l_rvalid = w_rsp_live &  rsp_ldr_q;
    f_err    = f_rvalid & rsp_err_q;
    l_err    = l_rvalid & rsp_err_q;
    f_rdata  = f_rvalid ? w_rsp_data : 32'h0;
    l_rdata  = l_rvalid ? w_rsp_data : 32'h0;
  end

  a_gnt_exclusive : assert property (@(posedge clk) !(f_gnt && l_gnt));
  a_men_needs_gnt : assert property (@(posedge clk) !m_en || w_gnt_any);
  a_no_gnt_in_rst : assert property (@(posedge clk) !reset || !(w_gnt_any || m_en));

endmodule
`default_nettype wire

// File: tb/tb_imem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_imem_arbiter                                              |
// | Description : Self-checking bench for imem_arbiter with a memory model.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_imem_arbiter;
  localparam int DEPTH    = 1024;
  localparam int MAX_WAIT = 4;
  localparam int AW       = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          f_req = 1'b0;
  logic [31:0]   f_addr = '0;
  logic          f_gnt, f_rvalid, f_err;
  logic [31:0]   f_rdata;
  logic          l_req = 1'b0, l_we = 1'b0, l_lock = 1'b0;
  logic [31:0]   l_addr = '0, l_wdata = '0;
  logic          l_gnt, l_rvalid, l_err;
  logic [31:0]   l_rdata;
  logic          m_en, m_we;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_wdata;
  logic [31:0]   m_rdata;

  imem_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt),
    .f_rvalid(f_rvalid), .f_rdata(f_rdata), .f_err(f_err),
    .l_req(l_req), .l_we(l_we), .l_lock(l_lock), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata), .l_err(l_err),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_pat(input logic [9:0] w);
    return {w, 6'h2A, ~w, 6'h15};
  endfunction

  // Synchronous single-port RAM, one-cycle read latency
  logic        mem_init = 1'b1;
  logic [31:0] mem [DEPTH];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= init_pat(10'(i));
    end else if (m_en) begin
      if (m_we) mem[m_addr] <= m_wdata;
      else      m_rdata     <= mem[m_addr];
    end
  end

  // ---------------- reference model ----------------
  typedef struct {
    bit          ldr;
    bit          err;
    logic [31:0] data;
  } rsp_t;

  rsp_t        pend[$];
  logic [31:0] ref_mem [int];
  bit          mdl_locked = 0;
  int          mdl_denied = 0;

  int n_chk  = 0;
  int n_fail = 0;

  logic          cap_fg, cap_lg, cap_men, cap_frv, cap_lrv;
  logic [AW-1:0] cap_maddr;
  logic [31:0]   cap_lrd;

  function automatic bit bad_addr(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:2] >= 30'(DEPTH));
  endfunction

  function automatic logic [31:0] ref_rd(input logic [9:0] w);
    return ref_mem.exists(int'(w)) ? ref_mem[int'(w)] : init_pat(w);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic cycle(input logic rs, input logic fr, input logic [31:0] fa,
                       input logic lr, input logic lw, input logic lk,
                       input logic [31:0] la, input logic [31:0] ld);
    rsp_t        r;
    bit          have, e_fg, e_lg, sel_bad, e_men, e_mwe;
    logic [9:0]  e_maddr, widx;
    logic [31:0] e_mwd;
    reset = rs; f_req = fr; f_addr = fa;
    l_req = lr; l_we = lw; l_lock = lk; l_addr = la; l_wdata = ld;
    @(negedge clk);
    have = 0;
    r = '{ldr: 1'b0, err: 1'b0, data: 32'h0};
    if (pend.size() > 0) begin
      r = pend.pop_front();
      have = !rs;
    end
    e_fg = 0; e_lg = 0;
    if (!rs) begin
      if (mdl_locked)    e_lg = lr;
      else if (fr && lr) begin e_lg = (mdl_denied >= MAX_WAIT); e_fg = !e_lg; end
      else begin e_fg = fr; e_lg = lr; end
    end
    sel_bad = e_lg ? bad_addr(la) : bad_addr(fa);
    widx    = e_lg ? la[11:2] : fa[11:2];
    e_men   = (e_fg || e_lg) && !sel_bad;
    e_mwe   = e_men && e_lg && lw;
    e_maddr = e_men ? widx : 10'h0;
    e_mwd   = e_men ? ld : 32'h0;

    chk("f_gnt",    32'(f_gnt),    32'(e_fg));
    chk("l_gnt",    32'(l_gnt),    32'(e_lg));
    chk("m_en",     32'(m_en),     32'(e_men));
    chk("m_we",     32'(m_we),     32'(e_mwe));
    chk("m_addr",   32'(m_addr),   32'(e_maddr));
    chk("m_wdata",  m_wdata,       e_mwd);
    chk("f_rvalid", 32'(f_rvalid), 32'(have && !r.ldr));
    chk("f_err",    32'(f_err),    32'(have && !r.ldr && r.err));
    chk("l_rvalid", 32'(l_rvalid), 32'(have && r.ldr));
    chk("l_err",    32'(l_err),    32'(have && r.ldr && r.err));
    if (have && !r.ldr) chk("f_rdata", f_rdata, r.data);
    if (have &&  r.ldr) chk("l_rdata", l_rdata, r.data);
    if (rs) begin
      chk("f_rdata_rst", f_rdata, 32'h0);
      chk("l_rdata_rst", l_rdata, 32'h0);
    end

    cap_fg = f_gnt; cap_lg = l_gnt; cap_men = m_en; cap_maddr = m_addr;
    cap_frv = f_rvalid; cap_lrv = l_rvalid; cap_lrd = l_rdata;

    if (e_fg || e_lg) begin
      r.ldr  = e_lg;
      r.err  = sel_bad;
      r.data = (sel_bad || (e_lg && lw)) ? 32'h0 : ref_rd(widx);
      pend.push_back(r);
    end
    if (e_mwe) ref_mem[int'(widx)] = ld;
    if (rs) begin
      mdl_locked = 0;
      mdl_denied = 0;
    end else begin
      if (mdl_locked || !lr || e_lg) mdl_denied = 0;
      else if (mdl_denied < MAX_WAIT) mdl_denied++;
      if (e_lg) mdl_locked = lk;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cycle(0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0);
  endtask

  task automatic do_reset();
    cycle(1, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0);
  endtask

  function automatic logic [31:0] rnd_addr();
    int r;
    r = $urandom_range(0, 15);
    if (r == 0)      return 32'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
    else if (r == 1) return 32'(DEPTH * 4 + $urandom_range(0, 15) * 4);
    else             return 32'($urandom_range(0, 31) * 4);
  endfunction

  typedef struct {
    logic        rst, fr;
    logic [31:0] fa;
    logic        lr, lw, lk;
    logic [31:0] la, ld;
    logic        fg, lg, men;
    logic [9:0]  maddr;
  } vec_t;

  vec_t tv [12];
  logic [31:0] wd [5];

  initial begin
    // rst fr  fa            lr lw lk la            ld             fg lg men maddr
    tv[0]  = '{1, 1, 32'h8,        1, 0, 0, 32'h0,        32'h0,          0, 0, 0, 10'd0};
    tv[1]  = '{0, 1, 32'h8,        0, 0, 0, 32'h0,        32'h0,          1, 0, 1, 10'd2};
    tv[2]  = '{0, 0, 32'h0,        0, 0, 0, 32'h0,        32'h0,          0, 0, 0, 10'd0};
    tv[3]  = '{0, 0, 32'h0,        1, 1, 0, 32'h10,       32'hDEAD_BEEF,  0, 1, 1, 10'd4};
    tv[4]  = '{0, 1, 32'h6,        0, 0, 0, 32'h0,        32'h0,          1, 0, 0, 10'd0};
    tv[5]  = '{0, 1, 32'h1000,     0, 0, 0, 32'h0,        32'h0,          1, 0, 0, 10'd0};
    tv[6]  = '{0, 0, 32'h0,        1, 0, 0, 32'h10,       32'h0,          0, 1, 1, 10'd4};
    tv[7]  = '{0, 0, 32'h0,        1, 0, 0, 32'h2,        32'h0,          0, 1, 0, 10'd0};
    tv[8]  = '{0, 1, 32'hC,        1, 0, 0, 32'h14,       32'h0,          1, 0, 1, 10'd3};
    tv[9]  = '{0, 0, 32'h0,        0, 0, 0, 32'h0,        32'h0,          0, 0, 0, 10'd0};
    tv[10] = '{0, 0, 32'h0,        1, 0, 0, 32'hFFC,      32'h0,          0, 1, 1, 10'd1023};
    tv[11] = '{0, 1, 32'hFFC,      0, 0, 0, 32'h0,        32'h0,          1, 0, 1, 10'd1023};

    @(posedge clk); #1;
    mem_init = 1'b0;
    do_reset();

    for (int i = 0; i < 12; i++) begin
      cycle(tv[i].rst, tv[i].fr, tv[i].fa, tv[i].lr, tv[i].lw, tv[i].lk, tv[i].la, tv[i].ld);
      chk($sformatf("tv%0d_fg", i),    32'(cap_fg),    32'(tv[i].fg));
      chk($sformatf("tv%0d_lg", i),    32'(cap_lg),    32'(tv[i].lg));
      chk($sformatf("tv%0d_men", i),   32'(cap_men),   32'(tv[i].men));
      chk($sformatf("tv%0d_maddr", i), 32'(cap_maddr), 32'(tv[i].maddr));
    end
    idle();

    // Continuous contention: F,F,F,F,L repeating
    do_reset();
    for (int k = 0; k < 15; k++) begin
      cycle(0, 1, 32'h20, 1, 0, 0, 32'h40, 32'h0);
      chk("starve_pattern", 32'(cap_lg), 32'((k % 5) == 4));
    end
    idle();

    // Locked burst: fetch shut out until the unlocking write
    do_reset();
    for (int i = 0; i < 5; i++) wd[i] = $urandom;
    cycle(0, 0, 32'h0, 1, 1, 1, 32'h0, wd[0]);
    chk("lock_first_lg", 32'(cap_lg), 32'h1);
    for (int i = 1; i < 4; i++) begin
      cycle(0, 1, 32'h4, 1, 1, 1, 32'(i * 4), wd[i]);
      chk("locked_fg", 32'(cap_fg), 32'h0);
      chk("locked_lg", 32'(cap_lg), 32'h1);
    end
    cycle(0, 1, 32'h4, 1, 1, 0, 32'h10, wd[4]);
    chk("unlock_fg", 32'(cap_fg), 32'h0);
    cycle(0, 1, 32'h4, 0, 0, 0, 32'h0, 32'h0);
    chk("after_unlock_fg", 32'(cap_fg), 32'h1);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 32'h0, 1, 0, 0, 32'(i * 4), 32'h0);
      if (i > 0) chk("readback", cap_lrd, wd[i-1]);
    end
    idle();
    chk("readback", cap_lrd, wd[4]);

    // Reset right after a grant: no response, wait count and lock cleared
    do_reset();
    cycle(0, 1, 32'h8, 1, 0, 0, 32'h40, 32'h0);
    cycle(0, 1, 32'h8, 1, 0, 0, 32'h40, 32'h0);
    cycle(0, 1, 32'h8, 1, 0, 0, 32'h40, 32'h0);
    chk("pre_rst_fg", 32'(cap_fg), 32'h1);
    cycle(1, 1, 32'h8, 1, 0, 0, 32'h40, 32'h0);
    chk("rst_no_frv", 32'(cap_frv), 32'h0);
    chk("rst_no_gnt", 32'(cap_fg | cap_lg), 32'h0);
    for (int k = 0; k < 5; k++) begin
      cycle(0, 1, 32'h8, 1, 0, 0, 32'h40, 32'h0);
      chk("post_rst_pattern", 32'(cap_lg), 32'(k == 4));
    end
    cycle(0, 0, 32'h0, 1, 1, 1, 32'h0, 32'h1234);
    cycle(1, 1, 32'h8, 0, 0, 0, 32'h0, 32'h0);
    chk("rst_no_lrv", 32'(cap_lrv), 32'h0);
    cycle(0, 1, 32'h8, 0, 0, 0, 32'h0, 32'h0);
    chk("rst_unlocks_fg", 32'(cap_fg), 32'h1);

    // Withdrawn loader request restarts the denial count
    do_reset();
    cycle(0, 1, 32'h8, 1, 0, 0, 32'h40, 32'h0);
    cycle(0, 1, 32'h8, 1, 0, 0, 32'h40, 32'h0);
    cycle(0, 1, 32'h8, 0, 0, 0, 32'h0,  32'h0);
    for (int k = 0; k < 5; k++) begin
      cycle(0, 1, 32'h8, 1, 0, 0, 32'h40, 32'h0);
      chk("withdraw_pattern", 32'(cap_lg), 32'(k == 4));
    end

    // Randomized traffic against the reference model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      cycle(($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)), rnd_addr(),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0), rnd_addr(), $urandom);
    end
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
